display_timing_sequencer: RTL and testbench

Frame timing controller for the display path: runs free-running horizontal and vertical position counters and decodes each into sync / back porch / display / front porch regions. It produces registered hsync, vsync, data-enable and pixel coordinates, and pulls pixels from an upstream source with a valid/ready handshake. Start/stop is frame-aligned, so the panel never sees a truncated frame. It sits between the frame source and the panel output stage.

---
 rtl/display_timing_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_display_timing_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_sequencer.sv
// display_timing_sequencer
//
// Frame timing controller for the display path. Free-running horizontal and
// vertical position counters are decoded into sync / back porch / display /
// front porch regions, producing registered sync, data-enable, coordinates
// and pixel data. Pixels are pulled from an upstream source by valid/ready.
// Start/stop is frame-aligned: once started, a frame always completes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             run request, sampled every cycle
//   busy               high while not idle
//   pix_valid/data     upstream pixel stream
//   pix_ready          combinational: pixel taken this cycle if pix_valid
//   hsync, vsync, de   registered timing outputs (1 clock after the counter)
//   x, y               active coordinates, 0 when de is low
//   rgb                pixel aligned with de, black when starved
//   frame_start        one-cycle pulse with position (0,0)
//   underflow          sticky starvation flag, only with DTG_UNDERFLOW_DETECT_EN
//
// Configuration macro: DTG_UNDERFLOW_DETECT_EN adds the underflow port/logic.
module display_timing_sequencer #(
   parameter int unsigned H_SYNC    = 10,
   parameter int unsigned H_BP      = 20,
   parameter int unsigned H_DISPLAY = 240,
   parameter int unsigned H_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 2,
   parameter int unsigned V_DISPLAY = 320,
   parameter int unsigned V_FP      = 4,
   parameter int unsigned DATA_W    = 16,
   localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_DISPLAY + H_FP,
   localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_DISPLAY + V_FP,
   localparam int unsigned H_BITS   = $clog2(H_TOTAL),
   localparam int unsigned V_BITS   = $clog2(V_TOTAL),
   localparam int unsigned X_BITS   = $clog2(H_DISPLAY),
   localparam int unsigned Y_BITS   = $clog2(V_DISPLAY)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   output logic              busy,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_data,
   output logic              pix_ready,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [X_BITS-1:0] x,
   output logic [Y_BITS-1:0] y,
   output logic [DATA_W-1:0] rgb,
   output logic              frame_start
`ifdef DTG_UNDERFLOW_DETECT_EN
   ,
   output logic              underflow
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   localparam logic [H_BITS-1:0] HLast    = H_BITS'(H_TOTAL - 1);
   localparam logic [V_BITS-1:0] VLast    = V_BITS'(V_TOTAL - 1);
   localparam logic [H_BITS-1:0] HSyncEnd = H_BITS'(H_SYNC);
   localparam logic [V_BITS-1:0] VSyncEnd = V_BITS'(V_SYNC);
   localparam logic [H_BITS-1:0] HActBeg  = H_BITS'(H_SYNC + H_BP);
   localparam logic [H_BITS-1:0] HActEnd  = H_BITS'(H_SYNC + H_BP + H_DISPLAY);
   localparam logic [V_BITS-1:0] VActBeg  = V_BITS'(V_SYNC + V_BP);
   localparam logic [V_BITS-1:0] VActEnd  = V_BITS'(V_SYNC + V_BP + V_DISPLAY);

   state_e              state_q, state_d;
   logic [H_BITS-1:0]   hcnt_q, hcnt_d;
   logic [V_BITS-1:0]   vcnt_q, vcnt_d;
   logic                hsync_q, hsync_d;
   logic                vsync_q, vsync_d;
   logic                de_q, de_d;
   logic [X_BITS-1:0]   x_q, x_d;
   logic [Y_BITS-1:0]   y_q, y_d;
   logic [DATA_W-1:0]   rgb_q, rgb_d;
   logic                frame_start_q, frame_start_d;
`ifdef DTG_UNDERFLOW_DETECT_EN
   logic                underflow_q, underflow_d;
`endif

   logic active;
   logic h_disp, v_disp, in_disp;
   logic h_last, v_last;

   assign active  = (state_q != StIdle);
   assign h_disp  = (hcnt_q >= HActBeg) && (hcnt_q < HActEnd);
   assign v_disp  = (vcnt_q >= VActBeg) && (vcnt_q < VActEnd);
   assign in_disp = h_disp && v_disp;
   assign h_last  = (hcnt_q == HLast);
   assign v_last  = (vcnt_q == VLast);

   assign busy      = active;
   assign pix_ready = active && in_disp;

   always_comb begin
      state_d       = state_q;
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      hsync_d       = 1'b0;
      vsync_d       = 1'b0;
      de_d          = 1'b0;
      x_d           = '0;
      y_d           = '0;
      rgb_d         = '0;
      frame_start_d = 1'b0;
`ifdef DTG_UNDERFLOW_DETECT_EN
      underflow_d   = underflow_q;
`endif
      unique case (state_q)
         StIdle: begin
            hcnt_d = '0;
            vcnt_d = '0;
            if (enable) begin
               state_d = StRun;
`ifdef DTG_UNDERFLOW_DETECT_EN
               underflow_d = 1'b0;
`endif
            end
         end
         StRun, StDrain: begin
            // Outputs describe the current position and appear one clock later.
            hsync_d       = (hcnt_q < HSyncEnd);
            vsync_d       = (vcnt_q < VSyncEnd);
            de_d          = in_disp;
            frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
            if (in_disp) begin
               x_d   = X_BITS'(hcnt_q - HActBeg);
               y_d   = Y_BITS'(vcnt_q - VActBeg);
               // Starved pixels are sent black; timing never stalls.
               rgb_d = pix_valid ? pix_data : '0;
`ifdef DTG_UNDERFLOW_DETECT_EN
               if (!pix_valid) underflow_d = 1'b1;
`endif
            end
            // Counters wrap naturally to (0,0) after the last position.
            hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
            if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            if (state_q == StRun) begin
               if (!enable) state_d = StDrain;
            end else if (enable) begin
               state_d = StRun;
            end else if (h_last && v_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
`ifdef DTG_UNDERFLOW_DETECT_EN
         underflow_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
`ifdef DTG_UNDERFLOW_DETECT_EN
         underflow_q   <= underflow_d;
`endif
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;
`ifdef DTG_UNDERFLOW_DETECT_EN
   assign underflow   = underflow_q;
`endif

endmodule

// File: tb/tb_display_timing_sequencer.sv
// Testbench for display_timing_sequencer with a 10x6 position frame.
// A reference model tracks the frame as a single position index (0..59) and
// derives regions with division/modulo; every output is compared each cycle.
module tb_display_timing_sequencer;
   localparam int HS = 2, HB = 2, HD = 4, HF = 2;
   localparam int VS = 1, VB = 1, VD = 3, VF = 1;
   localparam int HT = HS + HB + HD + HF;
   localparam int VT = VS + VB + VD + VF;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        pix_valid = 1'b0;
   logic [15:0] pix_data = '0;
   logic        busy, pix_ready, hsync, vsync, de, frame_start;
   logic [1:0]  x, y;
   logic [15:0] rgb;
`ifdef DTG_UNDERFLOW_DETECT_EN
   logic        underflow;
`endif

   display_timing_sequencer #(
      .H_SYNC(HS), .H_BP(HB), .H_DISPLAY(HD), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_DISPLAY(VD), .V_FP(VF),
      .DATA_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y), .rgb(rgb),
      .frame_start(frame_start)
`ifdef DTG_UNDERFLOW_DETECT_EN
      , .underflow(underflow)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: running flag, stop-at-frame-end flag, frame position.
   bit          m_on, m_stop;
   int          m_pos;
   logic        e_busy, e_hs, e_vs, e_de, e_fs, e_uf;
   logic [1:0]  e_x, e_y;
   logic [15:0] e_rgb;

   function automatic bit pos_disp(input int p);
      int h = p % HT;
      int v = p / HT;
      return (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
   endfunction

   task automatic model_reset();
      m_on = 0; m_stop = 0; m_pos = 0;
      e_busy = 0; e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_uf = 0;
      e_x = '0; e_y = '0; e_rgb = '0;
   endtask

   task automatic model_step(input logic en, input logic pv, input logic [15:0] pd);
      int h, v;
      bit d;
      if (!m_on) begin
         e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_x = '0; e_y = '0; e_rgb = '0;
         if (en) begin
            m_on = 1; m_stop = 0; m_pos = 0; e_uf = 0;
         end
      end else begin
         h = m_pos % HT;
         v = m_pos / HT;
         d = pos_disp(m_pos);
         e_hs  = (h < HS);
         e_vs  = (v < VS);
         e_de  = d;
         e_fs  = (m_pos == 0);
         e_x   = d ? 2'(h - HS - HB) : 2'd0;
         e_y   = d ? 2'(v - VS - VB) : 2'd0;
         e_rgb = (d && pv) ? pd : 16'h0;
         if (d && !pv) e_uf = 1;
         if (m_stop) begin
            if (en) m_stop = 0;
            else if (m_pos == FRAME - 1) m_on = 0;
         end else if (!en) begin
            m_stop = 1;
         end
         m_pos = m_on ? (m_pos + 1) % FRAME : 0;
      end
      e_busy = m_on;
   endtask

   int n_acc = 0;
   int t_fs, t_hs, t_vs, t_de, t_busy, t_acc;

   task automatic clear_tally();
      t_fs = 0; t_hs = 0; t_vs = 0; t_de = 0; t_busy = 0; t_acc = 0;
   endtask

   task automatic check_outputs();
      check_eq("busy", 32'(busy), 32'(e_busy));
      check_eq("hsync", 32'(hsync), 32'(e_hs));
      check_eq("vsync", 32'(vsync), 32'(e_vs));
      check_eq("de", 32'(de), 32'(e_de));
      check_eq("x", 32'(x), 32'(e_x));
      check_eq("y", 32'(y), 32'(e_y));
      check_eq("rgb", 32'(rgb), 32'(e_rgb));
      check_eq("frame_start", 32'(frame_start), 32'(e_fs));
`ifdef DTG_UNDERFLOW_DETECT_EN
      check_eq("underflow", 32'(underflow), 32'(e_uf));
`endif
   endtask

   // One clock: drive inputs, check pix_ready, take the edge, check outputs.
   task automatic cycle(input logic en, input logic pv, input logic [15:0] pd);
      bit rdy;
      enable = en; pix_valid = pv; pix_data = pd;
      #1;
      rdy = m_on && pos_disp(m_pos);
      check_eq("pix_ready", 32'(pix_ready), 32'(rdy));
      if (pix_ready && pix_valid) t_acc++;
      @(posedge clk);
      if (rst_n) model_step(en, pv, pd);
      else model_reset();
      if (rdy && pv) n_acc++;
      #1;
      check_outputs();
      t_fs += 32'(frame_start); t_hs += 32'(hsync); t_vs += 32'(vsync);
      t_de += 32'(de); t_busy += 32'(busy);
   endtask

   function automatic logic [15:0] seq_pix();
      return 16'(32'h1000 + n_acc);
   endfunction

   initial begin
      logic en_r;
      int   guard;
      model_reset();
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // Idle with enable low.
      clear_tally();
      repeat (20) cycle(1'b0, 1'b0, 16'h0);
      check_eq("idle_busy_cnt", 32'(t_busy), 32'd0);

      // Two full frames of continuous run.
      clear_tally();
      repeat (1 + 2 * FRAME) cycle(1'b1, 1'b1, seq_pix());
      check_eq("run_fs_cnt", 32'(t_fs), 32'd2);
      check_eq("run_hs_cnt", 32'(t_hs), 32'd24);
      check_eq("run_vs_cnt", 32'(t_vs), 32'd20);
      check_eq("run_de_cnt", 32'(t_de), 32'd24);
      check_eq("run_acc_cnt", 32'(t_acc), 32'd24);

      // Drop enable at position 25 of the next frame.
      repeat (25) cycle(1'b1, 1'b1, seq_pix());
      clear_tally();
      repeat (40) cycle(1'b0, 1'b1, seq_pix());
      check_eq("drain_busy_cnt", 32'(t_busy), 32'd34);
      check_eq("drain_fs_cnt", 32'(t_fs), 32'd0);
      check_eq("drain_busy_end", 32'(busy), 32'd0);

      // Restart, then pulse enable low for 3 clocks mid-frame.
      repeat (30) cycle(1'b1, 1'b1, seq_pix());
      repeat (3) cycle(1'b0, 1'b1, seq_pix());
      clear_tally();
      repeat (FRAME) cycle(1'b1, 1'b1, seq_pix());
      check_eq("toggle_fs_cnt", 32'(t_fs), 32'd1);
      check_eq("toggle_de_cnt", 32'(t_de), 32'd12);

      // Starve the pixel at x=2, y=1 (position 36).
      repeat (FRAME) cycle(1'b1, !(m_on && m_pos == 36), seq_pix());
`ifdef DTG_UNDERFLOW_DETECT_EN
      check_eq("underflow_sticky", 32'(underflow), 32'd1);
`endif

      // Asynchronous reset at position 33.
      guard = 0;
      while (m_pos != 33 && guard < 2 * FRAME) begin
         cycle(1'b1, 1'b1, seq_pix());
         guard++;
      end
      check_eq("reach_pos33", 32'(m_pos), 32'd33);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_hsync", 32'(hsync), 32'd0);
      check_eq("rst_vsync", 32'(vsync), 32'd0);
      check_eq("rst_de", 32'(de), 32'd0);
      check_eq("rst_rgb", 32'(rgb), 32'd0);
      check_eq("rst_fs", 32'(frame_start), 32'd0);
      check_eq("rst_ready", 32'(pix_ready), 32'd0);
`ifdef DTG_UNDERFLOW_DETECT_EN
      check_eq("rst_underflow", 32'(underflow), 32'd0);
`endif
      model_reset();
      @(posedge clk); #1;
      cycle(1'b0, 1'b0, 16'h0);
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, seq_pix());
      check_eq("restart_fs_edge1", 32'(frame_start), 32'd0);
      cycle(1'b1, 1'b1, seq_pix());
      check_eq("restart_fs_edge2", 32'(frame_start), 32'd1);

      // Randomized run: enable toggles, sporadic starvation, random pixels.
      en_r = 1'b1;
      repeat (900) begin
         if ($urandom_range(0, 24) == 0) en_r = ~en_r;
         cycle(en_r, ($urandom_range(0, 9) != 0), 16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
